// File: rtl/add.sv
// ---------------------------------------------------------------------------
// add -- WIDTH-bit unsigned ripple-carry adder with a zero-latency
//        combinational result and a one-cycle registered copy.
//
// Configuration macro:
//   ADD_CARRY_IN_EN  adds a 1-bit carry-in port (cin) after num2; it feeds
//                    the stage-0 carry. Undefined: carry-in is constant 0.
//
// Ports:
//   clk      rising-edge clock, used by the registered outputs only
//   rst_n    asynchronous active-low reset, clears all registered outputs
//   en       capture enable for the registered outputs
//   num1     operand A (unsigned, WIDTH bits)
//   num2     operand B (unsigned, WIDTH bits)
//   cin      carry-in (only with ADD_CARRY_IN_EN)
//   out      combinational sum, (num1 + num2 [+ cin]) mod 2^WIDTH
//   cout     combinational carry-out (bit WIDTH of the full sum)
//   ovf      combinational two's-complement overflow flag
//   sum_q    registered out
//   cout_q   registered cout
//   ovf_q    registered ovf
//   valid_q  high the cycle after an enabled capture
//
// Parameter:
//   WIDTH    operand / sum width in bits, 1..32 (default 4)
// ---------------------------------------------------------------------------
module add #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
`ifdef ADD_CARRY_IN_EN
    input  logic             cin,
`endif
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             ovf_q,
    output logic             valid_q
);

    // carry[i] is the carry into stage i; carry[WIDTH] is the final carry-out.
    logic [WIDTH:0] carry;

`ifdef ADD_CARRY_IN_EN
    assign carry[0] = cin;
`else
    assign carry[0] = 1'b0;
`endif

    // Explicit ripple chain of full adders. Kept purely combinational so the
    // sum never depends on clk, rst_n or en and stays valid during reset.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            logic prop;
            assign prop          = num1[gi] ^ num2[gi];
            assign out[gi]       = prop ^ carry[gi];
            assign carry[gi + 1] = (num1[gi] & num2[gi]) | (prop & carry[gi]);
        end
    endgenerate

    assign cout = carry[WIDTH];

    // Signed overflow: carry into the MSB differs from carry out of the MSB.
    // For WIDTH = 1 the "carry into the MSB" is the stage-0 carry-in.
    assign ovf = carry[WIDTH] ^ carry[WIDTH-1];

    // Registered copy. valid_q is a one-cycle strobe marking each capture;
    // the data registers hold their last captured value while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (en) begin
            sum_q   <= out;
            cout_q  <= cout;
            ovf_q   <= ovf;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add.sv
// ---------------------------------------------------------------------------
// tb_add -- self-checking bench for add (WIDTH = 4).
// Directed boundary cases plus randomized operands/enable, checked against an
// arithmetic reference model; the registered outputs are checked against a
// model updated at each rising clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_add;

    localparam int W = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [W-1:0] num1;
    logic [W-1:0] num2;
`ifdef ADD_CARRY_IN_EN
    logic         cin;
`endif
    logic [W-1:0] out;
    logic         cout;
    logic         ovf;
    logic [W-1:0] sum_q;
    logic         cout_q;
    logic         ovf_q;
    logic         valid_q;

    int checks = 0;
    int errors = 0;

    // Registered-output model state.
    logic [W-1:0] m_sum;
    logic         m_cout;
    logic         m_ovf;
    logic         m_valid;

    int cur_cin = 0;

    add #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .num1    (num1),
        .num2    (num2),
`ifdef ADD_CARRY_IN_EN
        .cin     (cin),
`endif
        .out     (out),
        .cout    (cout),
        .ovf     (ovf),
        .sum_q   (sum_q),
        .cout_q  (cout_q),
        .ovf_q   (ovf_q),
        .valid_q (valid_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (num1=%0d num2=%0d cin=%0d)",
                     tag, got, exp, num1, num2, cur_cin);
        end
    endtask

    // Reference: plain integer addition, sign rule for overflow.
    function automatic void ref_add(input int a, input int b, input int ci,
                                    output logic [W-1:0] s, output logic co,
                                    output logic ov);
        int full;
        int sa, sb, ss;
        full = a + b + ci;
        s    = W'(full & MASK);
        co   = ((full >> W) & 1) != 0;
        sa   = (a >> (W - 1)) & 1;
        sb   = (b >> (W - 1)) & 1;
        ss   = (int'(s) >> (W - 1)) & 1;
        ov   = (sa == sb) && (ss != sa);
    endfunction

    task automatic drive(input int a, input int b, input int ci);
        num1    = W'(a);
        num2    = W'(b);
        cur_cin = ci;
`ifdef ADD_CARRY_IN_EN
        cin     = ci[0];
`endif
    endtask

    task automatic check_comb(input string tag);
        logic [W-1:0] s;
        logic co, ov;
        ref_add(int'(num1), int'(num2), cur_cin, s, co, ov);
        check({tag, ".out"},  32'(out),  32'(s));
        check({tag, ".cout"}, 32'(cout), 32'(co));
        check({tag, ".ovf"},  32'(ovf),  32'(ov));
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".sum_q"},   32'(sum_q),   32'(m_sum));
        check({tag, ".cout_q"},  32'(cout_q),  32'(m_cout));
        check({tag, ".ovf_q"},   32'(ovf_q),   32'(m_ovf));
        check({tag, ".valid_q"}, 32'(valid_q), 32'(m_valid));
    endtask

    task automatic model_reset();
        m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_valid = 1'b0;
    endtask

    // Called just after a rising edge with the inputs that were stable at it.
    task automatic model_clock(input logic e, input int a, input int b, input int ci);
        logic [W-1:0] s;
        logic co, ov;
        if (e) begin
            ref_add(a, b, ci, s, co, ov);
            m_sum = s; m_cout = co; m_ovf = ov; m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    // Directed combinational cases: {num1, num2, exp_out, exp_cout, exp_ovf}
    int dir_tab [6][5] = '{
        '{0,  0,  0,  0, 0},
        '{1,  1,  2,  0, 0},
        '{5,  3,  8,  0, 1},
        '{7,  8,  15, 0, 0},
        '{15, 1,  0,  1, 0},
        '{10, 10, 4,  1, 1}
    };

    initial begin
        int a, b, ci;
        logic e;

        rst_n = 1'b0;
        en    = 1'b0;
        drive(0, 0, 0);
        model_reset();
        #10;
        check_regs("reset");

        // Combinational path with constant expectations, checked in reset.
        for (int i = 0; i < 6; i++) begin
            drive(dir_tab[i][0], dir_tab[i][1], 0);
            #10;
            check($sformatf("dir%0d.out", i),  32'(out),  32'(dir_tab[i][2]));
            check($sformatf("dir%0d.cout", i), 32'(cout), 32'(dir_tab[i][3]));
            check($sformatf("dir%0d.ovf", i),  32'(ovf),  32'(dir_tab[i][4]));
            $display("dir%0d: %0d + %0d -> out=%0d cout=%0d ovf=%0d",
                     i, num1, num2, out, cout, ovf);
        end
        // All-ones + all-ones boundary.
        drive(MASK, MASK, 0);
        #10;
        check("ones.out", 32'(out), 32'(MASK - 1));
        check("ones.cout", 32'(cout), 32'd1);
        check_regs("in_reset");

`ifdef ADD_CARRY_IN_EN
        drive(15, 0, 1);
        #10;
        check("cin1.out", 32'(out), 32'd0);
        check("cin1.cout", 32'(cout), 32'd1);
        drive(7, 8, 1);
        #10;
        check("cin2.out", 32'(out), 32'd0);
        check("cin2.cout", 32'(cout), 32'd1);
`endif

        // Release reset away from the edge, capture 10 + 10.
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        drive(10, 10, 0);
        @(posedge clk);
        model_clock(1'b1, 10, 10, 0);
        #1;
        check("cap.sum_q", 32'(sum_q), 32'd4);
        check("cap.cout_q", 32'(cout_q), 32'd1);
        check("cap.ovf_q", 32'(ovf_q), 32'd1);
        check("cap.valid_q", 32'(valid_q), 32'd1);
        $display("capture: sum_q=%0d cout_q=%0d ovf_q=%0d valid_q=%0d",
                 sum_q, cout_q, ovf_q, valid_q);

        // en low: data holds, valid drops.
        @(negedge clk);
        en = 1'b0;
        drive(1, 2, 0);
        @(posedge clk);
        model_clock(1'b0, 1, 2, 0);
        #1;
        check("hold.sum_q", 32'(sum_q), 32'd4);
        check("hold.valid_q", 32'(valid_q), 32'd0);
        check_regs("hold");

        // Randomized operands and enable.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            a  = int'($urandom_range(MASK, 0));
            b  = int'($urandom_range(MASK, 0));
`ifdef ADD_CARRY_IN_EN
            ci = int'($urandom_range(1, 0));
`else
            ci = 0;
`endif
            e  = 1'($urandom_range(1, 0));
            en = e;
            drive(a, b, ci);
            #1;
            check_comb($sformatf("rnd%0d", n));
            @(posedge clk);
            model_clock(e, a, b, ci);
            #1;
            check_regs($sformatf("rnd%0d", n));
            $display("rnd%0d: en=%0d %0d+%0d+%0d out=%0d cout=%0d ovf=%0d sum_q=%0d valid_q=%0d",
                     n, e, a, b, ci, out, cout, ovf, sum_q, valid_q);
        end

        // Asynchronous reset mid-cycle after a nonzero capture.
        @(negedge clk);
        en = 1'b1;
        drive(10, 10, 0);
        @(posedge clk);
        model_clock(1'b1, 10, 10, 0);
        #1;
        check_regs("pre_arst");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs("arst");
        check("arst.out", 32'(out), 32'd4);
        $display("async reset: sum_q=%0d cout_q=%0d ovf_q=%0d valid_q=%0d",
                 sum_q, cout_q, ovf_q, valid_q);

        // Reset held across an edge with en high still clears.
        @(posedge clk);
        #1;
        check_regs("arst_hold");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
